// File: rtl/ledctrl_wb_pkg.sv
// ledctrl_wb shared definitions: register map, CTRL bits, helpers.
// Used by the LED output stage and its PWM channels.
package ledctrl_wb_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'd8;
    localparam logic [3:0] ADDR_TORELOAD = 4'd9;

    localparam int CTRL_MANUAL  = 0;
    localparam int CTRL_AUTORET = 1;
    localparam int CTRL_TOEXP   = 2;

    function automatic int unsigned duty_ones(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int unsigned duty_zero(input int n);
        return 32'd0 & n;
    endfunction

    function automatic logic [31:0] wb_merge(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (sel[b])
                r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/ledctrl_wb_if.sv
// Pipelined Wishbone slave bundle for the LED control stage.
// Master drives the request side, slave returns stall/ack/data.
interface ledctrl_wb_if;

    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [3:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we,
        output i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we,
        input  i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_data
    );

endinterface

// File: rtl/ledpwm_chan.sv
// One LED PWM channel: compares bit-reversed counter with duty.
// Full-scale and zero duties are forced solid on / solid off.
module ledpwm_chan
    import ledctrl_wb_pkg::*;
#(
    parameter int NPWM = 7
) (
    input  logic [NPWM-1:0] br,
    input  logic [NPWM-1:0] duty,
    output logic            pwm
);

    localparam logic [NPWM-1:0] DUTY_ONES = NPWM'(duty_ones(NPWM));
    localparam logic [NPWM-1:0] DUTY_ZERO = NPWM'(duty_zero(NPWM));

    always_comb begin
        pwm = 1'b0;
        unique case (1'b1)
            (duty == DUTY_ONES): pwm = 1'b1;
            (duty == DUTY_ZERO): pwm = 1'b0;
            default:             pwm = (br < duty);
        endcase
    end

endmodule

// File: rtl/ledctrl_wb.sv
// LED output stage: registered pass-through of the pattern generator,
// or CPU-owned PWM until an inactivity timeout hands it back.
module ledctrl_wb
    import ledctrl_wb_pkg::*;
#(
    parameter int NLEDS  = 8,
    parameter int NPWM   = 7,
    parameter int TOBITS = 28
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    ledctrl_wb_if.slave      wb,
    input  logic [NLEDS-1:0] i_bounce,
    output logic [NLEDS-1:0] o_led
);

    localparam logic [3:0] NL = 4'(NLEDS);

    logic [NPWM-1:0]   duty [NLEDS];
    logic [NPWM-1:0]   pcnt;
    logic [NPWM-1:0]   br;
    logic [NLEDS-1:0]  pwm;
    logic [TOBITS-1:0] cnt, cnt_nxt;
    logic [TOBITS-1:0] reload, reload_nxt;
    logic              manual, manual_nxt;
    logic              autoret;
    logic              ack;
    logic [31:0]       rd, rdata;
    logic              acc, wr;

    assign acc = wb.i_wb_cyc && wb.i_wb_stb;
    assign wr  = acc && wb.i_wb_we;

    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_ack   = ack;
    assign wb.o_wb_data  = rd;

    always_comb begin
        br = '0;
        for (int i = 0; i < NPWM; i++)
            br[i] = pcnt[NPWM-1-i];
    end

    for (genvar k = 0; k < NLEDS; k++) begin : g_chan
        ledpwm_chan #(.NPWM(NPWM)) u_chan (
            .br   (br),
            .duty (duty[k]),
            .pwm  (pwm[k])
        );
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NLEDS; k++)
            if (wb.i_wb_addr == 4'(k))
                rdata[NPWM-1:0] = duty[k];
        unique case (1'b1)
            (wb.i_wb_addr == ADDR_CTRL): begin
                rdata[CTRL_MANUAL]  = manual;
                rdata[CTRL_AUTORET] = autoret;
                rdata[CTRL_TOEXP]   = (cnt == '0);
            end
            (wb.i_wb_addr == ADDR_TORELOAD):
                rdata = 32'(reload);
            default: ;
        endcase
    end

    // A write always beats a same-cycle expiry.
    always_comb begin
        reload_nxt = reload;
        cnt_nxt    = cnt;
        manual_nxt = manual;
        if (wr && wb.i_wb_addr == ADDR_TORELOAD)
            reload_nxt = TOBITS'(wb_merge(32'(reload),
                                          wb.i_wb_data,
                                          wb.i_wb_sel));
        if (wr) begin
            cnt_nxt = reload_nxt;
            if (wb.i_wb_addr < NL)
                manual_nxt = 1'b1;
            else if (wb.i_wb_addr == ADDR_CTRL && wb.i_wb_sel[0])
                manual_nxt = wb.i_wb_data[CTRL_MANUAL];
        end else if (cnt != '0) begin
            cnt_nxt = cnt - TOBITS'(1);
            if (cnt == TOBITS'(1) && autoret)
                manual_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NLEDS; k++)
                duty[k] <= '0;
            pcnt    <= '0;
            cnt     <= '0;
            reload  <= '1;
            manual  <= 1'b0;
            autoret <= 1'b1;
            ack     <= 1'b0;
            rd      <= '0;
            o_led   <= '0;
        end else begin
            for (int k = 0; k < NLEDS; k++)
                if (wr && wb.i_wb_addr == 4'(k))
                    duty[k] <= NPWM'(wb_merge(32'(duty[k]),
                                              wb.i_wb_data,
                                              wb.i_wb_sel));
            if (wr && wb.i_wb_addr == ADDR_CTRL && wb.i_wb_sel[0])
                autoret <= wb.i_wb_data[CTRL_AUTORET];
            pcnt   <= pcnt + NPWM'(1);
            cnt    <= cnt_nxt;
            reload <= reload_nxt;
            manual <= manual_nxt;
            ack    <= acc;
            rd     <= acc ? rdata : '0;
            o_led  <= manual ? pwm : i_bounce;
        end
    end

endmodule

// File: tb/tb_ledctrl_wb.sv
// Directed bench for ledctrl_wb: bus access, PWM duty counts,
// ownership timeout, write-vs-expiry race and reset mid-transfer.
module tb_ledctrl_wb;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [7:0] i_bounce = 8'h18;
    logic [7:0] o_led;

    int total = 0;
    int bad   = 0;

    ledctrl_wb_if bus ();

    ledctrl_wb u_dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .wb        (bus),
        .i_bounce  (i_bounce),
        .o_led     (o_led)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b1;
        bus.i_wb_addr = a; bus.i_wb_data = d; bus.i_wb_sel = s;
        @(posedge i_clk); #1;
        chk("wr_ack", 32'(bus.o_wb_ack), 32'd1);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = a;
        @(posedge i_clk); #1;
        chk("rd_ack", 32'(bus.o_wb_ack), 32'd1);
        d = bus.o_wb_data;
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int hi [8];
        int exp_hi [8];
        int low3;

        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;

        // reset state
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_led", 32'(o_led), 32'h0);
        chk("rst_ack", 32'(bus.o_wb_ack), 32'h0);
        chk("rst_data", bus.o_wb_data, 32'h0);
        chk("stall", 32'(bus.o_wb_stall), 32'h0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("pass_18", 32'(o_led), 32'h18);
        bus_rd(4'd8, d);
        chk("ctrl_rst", d, 32'h6);
        bus_rd(4'd9, d);
        chk("torl_rst", d, 32'h0fff_ffff);

        // duty programming and PWM high counts
        bus_wr(4'd3, 32'h7f, 4'hf);
        bus_wr(4'd0, 32'h00, 4'hf);
        bus_wr(4'd1, 32'h20, 4'hf);
        bus_wr(4'd2, 32'h20, 4'hf);
        bus_wr(4'd4, 32'h20, 4'hf);
        bus_wr(4'd5, 32'h20, 4'hf);
        bus_wr(4'd6, 32'h20, 4'hf);
        bus_wr(4'd7, 32'h20, 4'hf);
        exp_hi = '{0, 32, 32, 128, 32, 32, 32, 32};
        hi = '{default: 0};
        for (int c = 0; c < 128; c++) begin
            @(posedge i_clk); #1;
            for (int k = 0; k < 8; k++)
                hi[k] += int'(o_led[k]);
        end
        for (int k = 0; k < 8; k++)
            chk($sformatf("hi_cnt%0d", k), 32'(hi[k]), 32'(exp_hi[k]));
        bus_rd(4'd8, d);
        chk("ctrl_man", d, 32'h3);

        // timeout hands LEDs back to the generator
        i_bounce = 8'h81;
        bus_wr(4'd9, 32'd10, 4'hf);
        bus_wr(4'd1, 32'd5, 4'hf);
        repeat (10) @(posedge i_clk);
        #1;
        chk("to_e10_man", 32'(o_led[3]), 32'h1);
        @(posedge i_clk); #1;
        chk("to_e11_pass", 32'(o_led), 32'h81);

        // AUTORET=0 keeps manual ownership
        bus_wr(4'd8, 32'h1, 4'h1);
        bus_wr(4'd9, 32'd4, 4'hf);
        repeat (8) @(posedge i_clk);
        bus_rd(4'd8, d);
        chk("noret_ctrl", d, 32'h5);
        low3 = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk); #1;
            if (o_led[3] !== 1'b1) low3++;
        end
        chk("noret_hold", 32'(low3), 32'd0);

        // write in the expiry cycle wins, then expiry after reload
        bus_wr(4'd8, 32'h3, 4'h1);
        repeat (3) @(posedge i_clk);
        bus_wr(4'd8, 32'h3, 4'h1);
        low3 = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk); #1;
            if (o_led[3] !== 1'b1) low3++;
        end
        chk("race_hold", 32'(low3), 32'd0);
        @(posedge i_clk); #1;
        chk("race_exp", 32'(o_led), 32'h81);

        // back-to-back reads
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 4'd2;
        @(posedge i_clk); #1;
        chk("b2b_ack0", 32'(bus.o_wb_ack), 32'h1);
        chk("b2b_d0", bus.o_wb_data, 32'h20);
        @(negedge i_clk);
        bus.i_wb_addr = 4'd8;
        @(posedge i_clk); #1;
        chk("b2b_ack1", 32'(bus.o_wb_ack), 32'h1);
        chk("b2b_d1", bus.o_wb_data, 32'h6);
        @(negedge i_clk);
        bus.i_wb_addr = 4'd15;
        @(posedge i_clk); #1;
        chk("b2b_ack2", 32'(bus.o_wb_ack), 32'h1);
        chk("b2b_d2", bus.o_wb_data, 32'h0);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
        @(posedge i_clk); #1;
        chk("b2b_idle", 32'(bus.o_wb_ack), 32'h0);

        // byte selects on TORELOAD
        bus_wr(4'd9, 32'hffff_ff07, 4'h1);
        bus_rd(4'd9, d);
        chk("sel_torl", d, 32'h7);
        bus_wr(4'd15, 32'hffff_ffff, 4'hf);
        bus_rd(4'd15, d);
        chk("unmapped", d, 32'h0);

        // reset in the middle of a transfer, in manual mode
        bus_wr(4'd9, 32'h00ff_ffff, 4'hf);
        bus_wr(4'd2, 32'h20, 4'hf);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1; bus.i_wb_we = 1'b0;
        bus.i_wb_addr = 4'd2;
        @(posedge i_clk); #1;
        chk("mid_ack", 32'(bus.o_wb_ack), 32'h1);
        @(negedge i_clk);
        bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
        i_reset_n = 1'b0;
        i_bounce = 8'h18;
        @(posedge i_clk); #1;
        chk("mid_rst_led", 32'(o_led), 32'h0);
        chk("mid_rst_ack", 32'(bus.o_wb_ack), 32'h0);
        chk("mid_rst_dat", bus.o_wb_data, 32'h0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("post_rst_pass", 32'(o_led), 32'h18);
        bus_rd(4'd2, d);
        chk("post_rst_duty", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
